i2s_audio_fifo: RTL and testbench

- Sample buffer between the Wishbone audio register file and the I2S serializer / builtin DAC.
- Accepts one 48-bit stereo sample per `wr_valid` pulse: bits 47:24 = right, bits 23:0 = left.
- Holds up to 2^FIFO_LEN_BITS samples and presents the oldest to the consumer over a valid/ready handshake.
- Reports full, empty, low-threshold and level status back to the register file, plus sticky overflow/underrun error flags.

---
 rtl/i2s_audio_fifo.sv | 72 +++++++
 tb/tb_i2s_audio_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/i2s_audio_fifo.sv
// i2s_audio_fifo: show-ahead stereo sample buffer between the audio register file and the I2S/DAC consumer
//   clk, rst                 clock, asynchronous active-high reset
//   wr_data, wr_valid        sample push (one sample per strobe cycle)
//   rd_data, rd_valid, rd_ready  oldest sample, valid/ready pop handshake
//   fifo_threshold           low-water mark for fifo_low
//   fifo_level/full/empty/low    occupancy status
//   err_clr, overflow, underrun  sticky error flags and their clear
module i2s_audio_fifo #(
  parameter int FIFO_LEN_BITS = 4,
  parameter int DATA_WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  input  logic [FIFO_LEN_BITS:0]   fifo_threshold,
  output logic [FIFO_LEN_BITS:0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_low,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underrun
);
  localparam int DEPTH = 1 << FIFO_LEN_BITS;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_LEN_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LEN_BITS:0] level_q, level_d;
  logic ovf_q, ovf_d, udr_q, udr_d;
  logic push, pop;
  assign fifo_level = level_q;
  assign fifo_full = level_q == (FIFO_LEN_BITS+1)'(DEPTH);
  assign fifo_empty = level_q == '0;
  assign fifo_low = level_q < fifo_threshold;
  assign rd_valid = !fifo_empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign overflow = ovf_q;
  assign underrun = udr_q;
  assign pop = rd_valid & rd_ready;
  // a pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
  assign push = wr_valid & (!fifo_full | pop);
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + FIFO_LEN_BITS'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_LEN_BITS'(1) : rd_ptr_q;
    level_d = (push == pop) ? level_q : push ? level_q + (FIFO_LEN_BITS+1)'(1) : level_q - (FIFO_LEN_BITS+1)'(1);
    // clear wins over a same-cycle set
    ovf_d = err_clr ? 1'b0 : ovf_q | (wr_valid & !push);
    udr_d = err_clr ? 1'b0 : udr_q | (rd_ready & fifo_empty);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      udr_q <= udr_d;
    end
  end
  // sample storage carries no reset; contents are only observed while rd_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_i2s_audio_fifo.sv
module tb_i2s_audio_fifo;
  logic clk = 0, rst = 1, wr_valid = 0, rd_ready = 0, err_clr = 0;
  logic [47:0] wr_data = '0, rd_data;
  logic [4:0] fifo_threshold = 5'd4, fifo_level;
  logic rd_valid, fifo_full, fifo_empty, fifo_low, overflow, underrun;
  int total = 0, bad = 0;
  i2s_audio_fifo dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .fifo_threshold(fifo_threshold), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_low(fifo_low),
    .err_clr(err_clr), .overflow(overflow), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [47:0] v);
    wr_data = v;
    wr_valid = 1;
    tick();
    wr_valid = 0;
  endtask
  task automatic fill(input int base);
    for (int i = 0; i < 16; i++) push(48'(base + i));
  endtask
  task automatic drain(input int n);
    rd_ready = 1;
    for (int i = 0; i < n; i++) tick();
    rd_ready = 0;
  endtask
  initial begin
    #12;
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_empty", 64'(fifo_empty), 1);
    chk("rst_full", 64'(fifo_full), 0);
    chk("rst_rdvalid", 64'(rd_valid), 0);
    chk("rst_low", 64'(fifo_low), 1);
    #10 rst = 0;
    tick();
    push(48'hABCDEF_123456);
    chk("t1_valid", 64'(rd_valid), 1);
    chk("t1_data", 64'(rd_data), 64'hABCDEF_123456);
    chk("t1_level", 64'(fifo_level), 1);
    chk("t1_empty", 64'(fifo_empty), 0);
    drain(1);
    chk("t1_level0", 64'(fifo_level), 0);
    chk("t1_empty1", 64'(fifo_empty), 1);
    fill(0);
    chk("t2_full", 64'(fifo_full), 1);
    chk("t2_level", 64'(fifo_level), 16);
    chk("t2_noovf", 64'(overflow), 0);
    push(48'd77);
    chk("t2_ovf", 64'(overflow), 1);
    chk("t2_level_drop", 64'(fifo_level), 16);
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 64'(rd_data), 64'(i));
      tick();
    end
    rd_ready = 0;
    chk("t2_empty", 64'(fifo_empty), 1);
    chk("t2_noudr", 64'(underrun), 0);
    chk("t2_ovf_sticky", 64'(overflow), 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("t2_ovf_clr", 64'(overflow), 0);
    fill(100);
    wr_data = 48'd99;
    wr_valid = 1;
    rd_ready = 1;
    tick();
    wr_valid = 0;
    rd_ready = 0;
    chk("t3_level", 64'(fifo_level), 16);
    chk("t3_noovf", 64'(overflow), 0);
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", 64'(rd_data), (i < 15) ? 64'(101 + i) : 64'd99);
      tick();
    end
    rd_ready = 0;
    chk("t3_empty", 64'(fifo_empty), 1);
    fifo_threshold = 5'd4;
    for (int l = 0; l < 5; l++) begin
      #1 chk("t4_low_thr4", 64'(fifo_low), (l < 4) ? 64'd1 : 64'd0);
      push(48'(l));
    end
    drain(5);
    fifo_threshold = 5'd0;
    #1 chk("t4_low_thr0", 64'(fifo_low), 0);
    fill(0);
    fifo_threshold = 5'd20;
    #1 chk("t4_low_thr20", 64'(fifo_low), 1);
    drain(16);
    fifo_threshold = 5'd4;
    for (int i = 0; i < 3; i++) push(48'(200 + i));
    for (int i = 0; i < 40; i++) begin
      chk("t5_order", 64'(rd_data), 64'(200 + i));
      wr_data = 48'(203 + i);
      wr_valid = 1;
      rd_ready = 1;
      tick();
      chk("t5_level", 64'(fifo_level), 3);
    end
    wr_valid = 0;
    rd_ready = 0;
    rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_tail", 64'(rd_data), 64'(240 + i));
      tick();
    end
    rd_ready = 0;
    chk("t5_empty", 64'(fifo_empty), 1);
    fill(0);
    push(48'd1);
    drain(16);
    chk("t6_ovf_set", 64'(overflow), 1);
    rd_ready = 1;
    tick();
    rd_ready = 0;
    chk("t6_udr", 64'(underrun), 1);
    chk("t6_level0", 64'(fifo_level), 0);
    wr_valid = 1;
    for (int i = 0; i < 7; i++) begin
      wr_data = 48'(i);
      tick();
    end
    chk("t6_level7", 64'(fifo_level), 7);
    #2 rst = 1;
    #1;
    chk("t6_arst_level", 64'(fifo_level), 0);
    chk("t6_arst_empty", 64'(fifo_empty), 1);
    chk("t6_arst_ovf", 64'(overflow), 0);
    chk("t6_arst_udr", 64'(underrun), 0);
    chk("t6_arst_valid", 64'(rd_valid), 0);
    wr_valid = 0;
    tick();
    rst = 0;
    tick();
    chk("t6_post_level", 64'(fifo_level), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
